// File: rtl/video_pkg.sv
// video_pkg
//   Shared definitions for the video timing generator and the downstream
//   pixel stage: default 720p timing constants, the counter width, the
//   generator state enum and a small window-compare helper.
package video_pkg;

  // Width of the pixel and line counters
  localparam int CNT_W = 12;

  // Default 1280x720 timing, horizontal in pixels, vertical in lines
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vtg_state_t;

  // True when lo <= v < hi. One extra bit of width so that a bound equal
  // to the full 4096 count still compares correctly.
  function automatic logic in_window(input logic [CNT_W:0] v,
                                     input logic [CNT_W:0] lo,
                                     input logic [CNT_W:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// wrap_counter
//   12-bit counter that counts 0..MAX-1 and wraps back to 0.
//   Ports:
//     rfr_clk    - clock, rising edge
//     reset      - synchronous active-high reset, clears the count
//     clear      - load zero (takes priority over inc)
//     inc        - advance by one, wrapping after MAX-1
//     count      - registered count
//     count_next - value count takes on the next edge
//     tc         - terminal count, high while count == MAX-1
module wrap_counter
  import video_pkg::*;
#(
  parameter int MAX = 4096
) (
  input  logic             rfr_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  assign tc = (count == LAST);

  // Next value is exposed so the owner can register decodes that line up
  // with the count they describe.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = tc ? '0 : count + CNT_W'(1);
    end
  end

  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator: pixel/line counters plus registered
//   video_on, hsync, vsync and start-of-frame, all describing the
//   pixel_cnt/line_cnt shown in the same cycle.
//   Optional macro VTG_FRAME_CNT_EN adds a 16-bit frame counter output.
//   Ports:
//     rfr_clk   - pixel clock, rising edge
//     reset     - synchronous active-high reset
//     en        - run request; dropping it stops only at frame end
//     pixel_cnt - horizontal position 0..H_TOTAL-1
//     line_cnt  - vertical position 0..V_TOTAL-1
//     video_on  - high inside the active area
//     hsync     - horizontal sync, active level SYNC_POL
//     vsync     - vertical sync, active level SYNC_POL
//     sof       - one-cycle pulse at pixel 0, line 0
//     frame_cnt - (VTG_FRAME_CNT_EN only) completed-frame count
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             rfr_clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             sof
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SYNC_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SYNC_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  vtg_state_t       state, state_next;
  logic             h_clr, h_inc, h_tc;
  logic             v_clr, v_inc, v_tc;
  logic [CNT_W-1:0] h_next, v_next;

  wrap_counter #(.MAX(H_TOTAL)) u_h_cnt (
    .rfr_clk    (rfr_clk),
    .reset      (reset),
    .clear      (h_clr),
    .inc        (h_inc),
    .count      (pixel_cnt),
    .count_next (h_next),
    .tc         (h_tc)
  );

  wrap_counter #(.MAX(V_TOTAL)) u_v_cnt (
    .rfr_clk    (rfr_clk),
    .reset      (reset),
    .clear      (v_clr),
    .inc        (v_inc),
    .count      (line_cnt),
    .count_next (v_next),
    .tc         (v_tc)
  );

  // State register.
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and counter control. en is only looked at in IDLE and on
  // the very last pixel of a frame, so mid-frame toggles never disturb the
  // raster. Leaving IDLE keeps the counters at zero so the first RUN cycle
  // shows pixel 0, line 0.
  always_comb begin
    state_next = state;
    h_clr      = 1'b0;
    h_inc      = 1'b0;
    v_clr      = 1'b0;
    v_inc      = 1'b0;
    case (state)
      IDLE: begin
        h_clr = 1'b1;
        v_clr = 1'b1;
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (h_tc && v_tc && !en) begin
          state_next = IDLE;
          h_clr      = 1'b1;
          v_clr      = 1'b1;
        end else begin
          h_inc = 1'b1;
          v_inc = h_tc;
        end
      end
      default: begin
        state_next = IDLE;
        h_clr      = 1'b1;
        v_clr      = 1'b1;
      end
    endcase
  end

  // Registered decodes, computed from the counters' next values so they
  // land on the same edge as the position they describe.
  always_ff @(posedge rfr_clk) begin
    if (reset || (state_next == IDLE)) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      sof      <= 1'b0;
    end else begin
      video_on <= ({1'b0, h_next} < H_ACT_END) && ({1'b0, v_next} < V_ACT_END);
      hsync    <= in_window({1'b0, h_next}, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync    <= in_window({1'b0, v_next}, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      sof      <= (h_next == '0) && (v_next == '0);
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Counts only seamless frame-to-frame wraps, so the first sof after IDLE
  // does not bump it. The new value appears together with sof.
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if ((state == RUN) && (state_next == RUN) &&
                 (h_next == '0) && (v_next == '0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 1280, visible pixels per line.
- H_FP, 110, horizontal front porch in pixels.
- H_SYNC, 40, hsync width in pixels.
- H_BP, 220, horizontal back porch in pixels.
- V_ACTIVE, 720, visible lines per frame.
- V_FP, 5, vertical front porch in lines.
- V_SYNC, 5, vsync width in lines.
- V_BP, 20, vertical back porch in lines.
- SYNC_POL, 1, active level of hsync/vsync.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- rfr_clk, in, 1, pixel clock; one clock only, all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- en, in, 1, run request.
- pixel_cnt, out, 12, horizontal position 0..H_TOTAL-1.
- line_cnt, out, 12, vertical position 0..V_TOTAL-1.
- video_on, out, 1, high inside the active area.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- sof, out, 1, one-cycle start-of-frame pulse.
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650), and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (default 750).

Function
REQ-004 The block SHALL be a two-state FSM with states IDLE and RUN.
REQ-005 In IDLE: pixel_cnt=0, line_cnt=0, video_on=0, sof=0, hsync=vsync=!SYNC_POL.
REQ-006 IDLE->RUN on the first edge with en=1; in that same cycle outputs SHALL show pixel 0, line 0, video_on=1, sof=1.
REQ-007 In RUN, pixel_cnt SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0, with line_cnt incrementing on that wrap.
REQ-008 line_cnt SHALL wrap from V_TOTAL-1 to 0 when pixel_cnt wraps on line V_TOTAL-1.
REQ-009 All outputs SHALL be registered and mutually cycle-aligned: video_on, hsync, vsync and sof describe the pixel_cnt/line_cnt shown in the same cycle.
REQ-010 video_on SHALL be 1 iff pixel_cnt<H_ACTIVE and line_cnt<V_ACTIVE.
REQ-011 hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= pixel_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-012 vsync SHALL equal SYNC_POL for whole lines with V_ACTIVE+V_FP <= line_cnt < V_ACTIVE+V_FP+V_SYNC, changing with pixel_cnt=0.
REQ-013 sof SHALL be 1 exactly when pixel_cnt=0 and line_cnt=0 in RUN.
REQ-014 en=0 in RUN SHALL take effect only at frame end: after pixel H_TOTAL-1 of line V_TOTAL-1 the FSM enters IDLE, so no partial frame is ever emitted.
REQ-015 en=1 at frame end SHALL continue seamlessly into the next frame, which starts with sof=1.
REQ-016 en toggling mid-frame SHALL NOT disturb the counters.
REQ-017 Counter arithmetic SHALL be 12-bit unsigned with no overflow for any parameter set giving H_TOTAL and V_TOTAL <= 4096.

Reset
REQ-018 reset=1 on an edge SHALL force IDLE and the REQ-005 output values on that edge, overriding en and any mid-frame state.
REQ-019 After reset is released, the FSM SHALL wait in IDLE until en=1 is sampled.

Configuration
REQ-020 Macro VTG_FRAME_CNT_EN SHALL control frame counting.
- Defined: an extra output frame_cnt[15:0] is present; it resets to 0, increments on each cycle where sof=1 except the first after IDLE, and wraps 65535->0.
- Not defined: the port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-021 Default 720p timing constants and a state enum (IDLE, RUN) SHALL live in the shared package video_pkg, which the block and the downstream pixel stage both import.
REQ-022 One sub-module SHALL be used, wrap_counter (12-bit, load-zero, increment, terminal-count flag), instantiated twice: once for horizontal and once for vertical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset held 3 cycles, en=0 -> all outputs at REQ-005 values; still IDLE 10 cycles after release.
- en=1 after reset -> first RUN cycle shows pixel 0, line 0, sof=1, video_on=1; pixel 1279 gives video_on=1, pixel 1280 gives video_on=0.
- Line 0 -> hsync=1 for pixels 1390..1429 (40 cycles), 0 at pixels 1389 and 1430.
- Full frame -> vsync=1 on lines 725..729 only; next sof exactly 1,237,500 cycles after the previous one.
- en dropped at line 300 -> counting continues to (1649,749), then IDLE; raising en again restarts with sof=1.
- reset asserted at pixel 700 of line 400 -> next edge pixel_cnt=0, line_cnt=0, video_on=0, syncs inactive; with VTG_FRAME_CNT_EN, frame_cnt=0.
